// File: rtl/branch_predictor_gshare_param.sv
// Gshare predictor: counter table indexed by pc XOR speculative global history.
// Define BP_STATS_EN to add branch / mispredict statistics outputs.
module branch_predictor_gshare_param #(
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_prediction,
  output logic [GHR_BITS-1:0]   o_req_ghr,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic [GHR_BITS-1:0]   i_fb_ghr,
  input  logic                  i_fb_prediction,
  input  logic                  i_fb_outcome,
`ifdef BP_STATS_EN
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts,
`endif
  output logic                  o_ready
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [INDEX_BITS-1:0] LAST_IDX = {INDEX_BITS{1'b1}};

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [CTR_BITS-1:0]   table_q [ENTRIES];

  logic                  run;
  logic [INDEX_BITS-1:0] req_idx, fb_idx;
  logic [CTR_BITS-1:0]   req_ctr, fb_ctr, fb_ctr_next;
  logic                  pred_bit, mispredict;

  assign run        = (state_q == ST_RUN);
  assign req_idx    = i_req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
  assign fb_idx     = i_fb_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(i_fb_ghr);
  assign req_ctr    = table_q[req_idx];
  assign fb_ctr     = table_q[fb_idx];
  assign pred_bit   = req_ctr[CTR_BITS-1];
  assign mispredict = (i_fb_prediction != i_fb_outcome);
  assign o_req_ghr  = ghr_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_idx_q == LAST_IDX) state_d = ST_RUN;
  end

  // FSM: outputs
  always_comb begin
    o_ready          = run;
    o_req_prediction = run & pred_bit;
  end

  always_comb begin
    fb_ctr_next = fb_ctr;
    if (i_fb_outcome && fb_ctr != CTR_MAX)             fb_ctr_next = fb_ctr + 1'b1;
    else if (!i_fb_outcome && fb_ctr != '0)            fb_ctr_next = fb_ctr - 1'b1;
  end

  // Recovery outranks the speculative shift: that request is on the squashed path.
  always_comb begin
    init_idx_d = init_idx_q;
    ghr_d      = ghr_q;
    if (!run)                         init_idx_d = init_idx_q + 1'b1;
    else if (i_fb_valid && mispredict) ghr_d = (i_fb_ghr << 1) | GHR_BITS'(i_fb_outcome);
    else if (i_req_valid)             ghr_d = (ghr_q << 1) | GHR_BITS'(pred_bit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
    end
  end

  // Table has no reset; the init walk defines every entry before RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)            table_q[init_idx_q] <= CTR_INIT;
      else if (i_fb_valid) table_q[fb_idx]     <= fb_ctr_next;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (run && i_fb_valid) begin
      if (stat_br_q != 32'hFFFF_FFFF)                stat_br_q  <= stat_br_q + 32'd1;
      if (mispredict && stat_mis_q != 32'hFFFF_FFFF) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign o_stat_branches    = stat_br_q;
  assign o_stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare_param.sv
// Bench for branch_predictor_gshare_param (4/4/2 configuration): directed test-plan
// scenarios with literal expectations, then randomized traffic against a reference model.
module tb_branch_predictor_gshare_param;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic [31:0] i_req_pc;
  logic        o_req_prediction;
  logic [3:0]  o_req_ghr;
  logic        i_fb_valid;
  logic [31:0] i_fb_pc;
  logic [3:0]  i_fb_ghr;
  logic        i_fb_prediction;
  logic        i_fb_outcome;
  logic        o_ready;
`ifdef BP_STATS_EN
  logic [31:0] o_stat_branches;
  logic [31:0] o_stat_mispredicts;
`endif

  branch_predictor_gshare_param #(
    .INDEX_BITS(4), .GHR_BITS(4), .CTR_BITS(2), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_pc(i_req_pc),
    .o_req_prediction(o_req_prediction), .o_req_ghr(o_req_ghr),
    .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_ghr(i_fb_ghr),
    .i_fb_prediction(i_fb_prediction), .i_fb_outcome(i_fb_outcome),
`ifdef BP_STATS_EN
    .o_stat_branches(o_stat_branches), .o_stat_mispredicts(o_stat_mispredicts),
`endif
    .o_ready(o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 0;

  // Reference model: counters as plain ints, readiness from elapsed cycles.
  int      m_ctr [16];
  int      m_ghr;
  bit      m_ready;
  int      m_cycles;
  longint  m_br, m_mis;

  function automatic int idx_of(logic [31:0] pc, int g);
    return ((pc >> 2) & 15) ^ g;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int p, f, new_ghr;
    bit pbit;
    if (!rst_n) begin
      m_ready = 0; m_cycles = 0; m_ghr = 0; m_br = 0; m_mis = 0;
    end else if (!m_ready) begin
      m_cycles++;
      if (m_cycles == 16) begin
        foreach (m_ctr[k]) m_ctr[k] = 1;
        m_ready = 1;
      end
    end else begin
      p = idx_of(i_req_pc, m_ghr);
      pbit = (m_ctr[p] >= 2);
      new_ghr = m_ghr;
      if (i_req_valid) new_ghr = ((m_ghr << 1) | int'(pbit)) & 15;
      if (i_fb_valid) begin
        f = idx_of(i_fb_pc, int'(i_fb_ghr));
        if (i_fb_outcome) m_ctr[f] = (m_ctr[f] == 3) ? 3 : m_ctr[f] + 1;
        else              m_ctr[f] = (m_ctr[f] == 0) ? 0 : m_ctr[f] - 1;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (i_fb_prediction != i_fb_outcome) begin
          if (m_mis < 64'hFFFF_FFFF) m_mis++;
          new_ghr = ((int'(i_fb_ghr) << 1) | int'(i_fb_outcome)) & 15;
        end
      end
      m_ghr = new_ghr;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: outputs are combinational, so check mid-cycle every cycle.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("ready", 64'(o_ready), 64'(m_ready));
      chk("ghr", 64'(o_req_ghr), 64'(m_ready ? m_ghr : 0));
      chk("pred", 64'(o_req_prediction),
          64'(m_ready ? (m_ctr[idx_of(i_req_pc, m_ghr)] >= 2) : 0));
`ifdef BP_STATS_EN
      chk("stat_br", 64'(o_stat_branches), 64'(m_br));
      chk("stat_mis", 64'(o_stat_mispredicts), 64'(m_mis));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fb(logic [31:0] pc, logic [3:0] g, logic pred, logic outc);
    i_fb_valid = 1; i_fb_pc = pc; i_fb_ghr = g; i_fb_prediction = pred; i_fb_outcome = outc;
    tick();
    i_fb_valid = 0;
  endtask

  initial begin
    rst_n = 0; i_req_valid = 0; i_req_pc = 0;
    i_fb_valid = 0; i_fb_pc = 0; i_fb_ghr = 0; i_fb_prediction = 0; i_fb_outcome = 0;
    tick();
    checking = 1;
    tick(); tick();
    rst_n = 1;

    // Init: 16 cycles not ready, requests answered NOT_TAKEN; ready on cycle 17.
    for (int c = 1; c <= 16; c++) begin
      i_req_valid = 1; i_req_pc = $urandom;
      @(negedge clk);
      chk("init_ready", 64'(o_ready), 0);
      chk("init_pred", 64'(o_req_prediction), 0);
      tick();
    end
    i_req_valid = 0; i_req_pc = 32'h40;
    @(negedge clk);
    chk("ready_c17", 64'(o_ready), 1);
    chk("ghr_after_init", 64'(o_req_ghr), 0);
    tick();

    // Train pc 0x40 (index 0) up, then back down.
    fb(32'h40, 4'h0, 1, 1);
    fb(32'h40, 4'h0, 1, 1);
    @(negedge clk);
    chk("pc40_taken", 64'(o_req_prediction), 1);
    tick();
    fb(32'h40, 4'h0, 1, 0);
    fb(32'h40, 4'h0, 1, 0);
    @(negedge clk);
    chk("pc40_not_taken", 64'(o_req_prediction), 0);
    tick();

    // Saturation on index 1: five TAKEN then one NOT_TAKEN stays TAKEN.
    for (int k = 0; k < 5; k++) fb(32'h44, 4'h0, 1, 1);
    fb(32'h44, 4'h0, 1, 0);
    i_req_pc = 32'h44;
    @(negedge clk);
    chk("sat_pred", 64'(o_req_prediction), 1);
    chk("sat_ghr", 64'(o_req_ghr), 0);
    tick();

    // Speculative history: indices 2,3,1 trained taken, three requests from pc 0x08.
    fb(32'h08, 4'h0, 1, 1);
    fb(32'h0C, 4'h0, 1, 1);
    i_req_valid = 1; i_req_pc = 32'h08;
    tick(); tick(); tick();
    i_req_valid = 0;
    @(negedge clk);
    chk("spec_ghr_0111", 64'(o_req_ghr), 64'h7);
    tick();
    i_req_valid = 1; i_req_pc = 32'h08;
    fb(32'h30, 4'h1, 1, 0);
    i_req_valid = 0;
    @(negedge clk);
    chk("recover_ghr_0010", 64'(o_req_ghr), 64'h2);
    tick();

    // Reset mid-RUN; feedback during init must be ignored.
    rst_n = 0;
    tick();
    @(negedge clk);
    chk("rst_ready_drop", 64'(o_ready), 0);
    chk("rst_ghr", 64'(o_req_ghr), 0);
    tick();
    rst_n = 1;
    for (int c = 0; c < 16; c++) begin
      i_fb_valid = 1; i_fb_pc = $urandom; i_fb_ghr = 4'($urandom);
      i_fb_prediction = 0; i_fb_outcome = 1;
      tick();
    end
    i_fb_valid = 0;
    for (int k = 0; k < 16; k++) begin
      i_req_pc = 32'(k * 4);
      @(negedge clk);
      chk("post_rst_nt", 64'(o_req_prediction), 0);
      tick();
    end

    // Ten feedbacks, three mispredicted.
    for (int k = 0; k < 10; k++) fb(32'(32'h80 + k * 4), 4'h0, (k % 4 == 0) ? 1'b0 : 1'b1, 1'b1);
`ifdef BP_STATS_EN
    @(negedge clk);
    chk("stat_br_10", 64'(o_stat_branches), 10);
    chk("stat_mis_3", 64'(o_stat_mispredicts), 3);
    tick();
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n           = ($urandom_range(0, 399) != 0);
      i_req_valid     = $urandom_range(0, 1);
      i_req_pc        = $urandom;
      i_fb_valid      = ($urandom_range(0, 2) != 0);
      i_fb_pc         = $urandom;
      i_fb_ghr        = 4'($urandom);
      i_fb_prediction = $urandom_range(0, 1);
      i_fb_outcome    = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1; i_req_valid = 0; i_fb_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare_param.md
# branch_predictor_gshare_param

Parametrised gshare branch predictor and the successor to the single-counter 2-bit predictor behind `branch_controller`. It keeps a table of saturating counters indexed by PC XOR a speculative global history register (GHR). It answers decode-stage prediction requests combinationally and trains on execute-stage feedback. It restores the GHR on a misprediction and clears its table with a sequential init walk after reset.

## Interface
Parameters:
- `INDEX_BITS`, default 8: table has 2^INDEX_BITS counters; must be ≥ GHR_BITS.
- `GHR_BITS`, default 8: global history length (1..INDEX_BITS).
- `CTR_BITS`, default 2: counter width (2..4).

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `i_req_valid`  in  1  decode has a conditional branch needing a prediction.
- `i_req_pc`  in  `ADDR_WIDTH`  branch PC.
- `o_req_prediction`  out  BranchOutcome  TAKEN/NOT_TAKEN.
- `o_req_ghr`  out  GHR_BITS  GHR snapshot used for this prediction; carried down the pipe.
- `i_fb_valid`  in  1  execute resolves a conditional branch.
- `i_fb_pc`  in  `ADDR_WIDTH`  resolved branch PC.
- `i_fb_ghr`  in  GHR_BITS  snapshot returned from `o_req_ghr`.
- `i_fb_prediction`  in  BranchOutcome  prediction that was made.
- `i_fb_outcome`  in  BranchOutcome  actual outcome.
- `o_ready`  out  1  high once the init walk is complete.

## Operation
- Index = `pc[INDEX_BITS+1:2]` XOR zero-extended GHR. Request uses the live GHR. Feedback uses `i_fb_ghr`.
- Prediction = MSB of the indexed counter. The table is held in flops and read combinationally.
- FSM:
  - INIT: writes weakly-not-taken, 2^(CTR_BITS-1)-1, to entry `init_idx`, then increments `init_idx`. Moves to RUN after the last entry.
  - RUN: normal operation.
  - Reset from any state returns to INIT with `init_idx`=0.
- In INIT: `o_req_prediction`=NOT_TAKEN, `o_ready`=0, feedback ignored, GHR held at 0.
- Speculative history: in RUN with `i_req_valid`, GHR <= {GHR[GHR_BITS-2:0], predicted_bit}.
- Training: in RUN with `i_fb_valid`, the counter at the feedback index saturating-increments on TAKEN and saturating-decrements on NOT_TAKEN. It never wraps past 0 or 2^CTR_BITS-1.
- Recovery: when `i_fb_valid` and `i_fb_outcome` != `i_fb_prediction`, GHR <= {i_fb_ghr[GHR_BITS-2:0], outcome_bit}.
- Simultaneous request and mispredict feedback: recovery wins and the request's shift is dropped, because that request is on the squashed path.
- Request and feedback on the same index in the same cycle: the prediction sees the pre-update counter value.

## Timing
- Prediction latency: 0 cycles, combinational from `i_req_pc` and state.
- Counter and GHR updates become visible the cycle after the feedback or request edge.
- Init lasts exactly 2^INDEX_BITS cycles after `rst_n` deasserts. `o_ready` rises on the following cycle.
- Reset values:
  - `o_req_prediction`=NOT_TAKEN, `o_ready`=0, `o_req_ghr`=0, GHR=0.
  - Table contents are undefined until INIT completes.
  - Stats counters (when enabled) = 0.

## Configuration
- Macro `BP_STATS_EN`.
- When defined, the block adds outputs `o_stat_branches` [31:0] and `o_stat_mispredicts` [31:0].
  - Each counts RUN-state `i_fb_valid` events and mispredicted events respectively.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and their logic are absent. Prediction behaviour is identical in both builds.

## Test plan
All scenarios use INDEX_BITS=4, GHR_BITS=4, CTR_BITS=2.
- Reset then idle: `o_ready`=0 for 16 cycles, 1 on cycle 17. Any request during init -> NOT_TAKEN.
- Train pc=0x40 with GHR held 0 (feedback i_fb_ghr=0, TAKEN, prediction=TAKEN) twice. Counter goes 01->10->11. Request pc=0x40 with GHR=0 -> TAKEN. Two NOT_TAKEN feedbacks -> 01 -> NOT_TAKEN.
- Saturation: five TAKEN feedbacks to one index leave the counter at 11. One NOT_TAKEN leaves it at 10, so the prediction is still TAKEN.
- Speculative history: three requests predicted TAKEN from GHR=0 -> `o_req_ghr`=0b0111. Mispredict feedback with i_fb_ghr=0b0001 and outcome NOT_TAKEN, issued together with a request -> GHR=0b0010 next cycle, with the request's shift dropped.
- Reset asserted mid-RUN after training: `o_ready` drops. After 16 cycles every index predicts NOT_TAKEN again.
- With `BP_STATS_EN`: 10 feedbacks, 3 of them mispredicted -> `o_stat_branches`=10, `o_stat_mispredicts`=3. Feedbacks during INIT are not counted.
